// File: rtl/vdc_pkg.sv
// Shared types, palette constants and RGBI palette expansion for the VDC video path.
package vdc_pkg;

  typedef logic [3:0] rgbi_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  localparam logic [7:0] PAL_LO           = 8'h55;
  localparam logic [7:0] PAL_HI           = 8'hAA;
  localparam rgbi_t      RGBI_DARK_YELLOW = 4'b1100;

  // [3]=R [2]=G [1]=B [0]=I; dark yellow is pulled down to brown on green.
  function automatic rgb24_t rgbi2rgb(input rgbi_t c);
    rgb24_t     o;
    logic [7:0] base;
    base = c[0] ? PAL_LO : 8'h00;
    o.r  = base | (c[3] ? PAL_HI : 8'h00);
    o.g  = base | (c[2] ? PAL_HI : 8'h00);
    o.b  = base | (c[1] ? PAL_HI : 8'h00);
    if (c == RGBI_DARK_YELLOW) o.g = PAL_LO;
    return o;
  endfunction

endpackage

// File: rtl/vdc_video_out_if.sv
// Pixel bus between the VDC core side and the video output stage.
interface vdc_video_out_if;
  import vdc_pkg::*;

  logic       pixelclk;
  rgbi_t      rgbi_in;
  logic       hsync_in;
  logic       vsync_in;
  logic       hblank_in;
  logic       vblank_in;
  logic       field_in;
  logic       disable_in;

  logic       ce_pix;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       hs;
  logic       vs;
  logic       hbl;
  logic       vbl;
  logic       field;
  logic       hpol;
  logic       vpol;

  modport master (
    output pixelclk, rgbi_in, hsync_in, vsync_in, hblank_in, vblank_in, field_in, disable_in,
    input  ce_pix, r, g, b, hs, vs, hbl, vbl, field, hpol, vpol
  );

  modport slave (
    input  pixelclk, rgbi_in, hsync_in, vsync_in, hblank_in, vblank_in, field_in, disable_in,
    output ce_pix, r, g, b, hs, vs, hbl, vbl, field, hpol, vpol
  );

endinterface

// File: rtl/vdc_syncpol.sv
// Sync polarity detector: measures high/low run lengths and declares the shorter level active.
module vdc_syncpol #(
  parameter int unsigned POL_CNT_BITS = 12
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cnt_en,
  input  logic sample_en,
  input  logic sync_in,
  output logic pol
);

  typedef logic [POL_CNT_BITS-1:0] len_t;

  localparam len_t CNT_ONE = len_t'(1);
  localparam len_t CNT_MAX = '1;

  logic level_q, level_d;
  len_t cnt_q, cnt_d;
  len_t hi_len_q, hi_len_d;
  len_t lo_len_q, lo_len_d;
  logic hi_v_q, hi_v_d;
  logic lo_v_q, lo_v_d;
  logic pol_q, pol_d;

  always_comb begin
    level_d  = level_q;
    cnt_d    = cnt_q;
    hi_len_d = hi_len_q;
    lo_len_d = lo_len_q;
    hi_v_d   = hi_v_q;
    lo_v_d   = lo_v_q;
    pol_d    = pol_q;
    if (sample_en && (sync_in != level_q)) begin
      level_d = sync_in;
      cnt_d   = CNT_ONE;
      if (level_q) begin
        hi_len_d = cnt_q;
        hi_v_d   = 1'b1;
      end else begin
        lo_len_d = cnt_q;
        lo_v_d   = 1'b1;
      end
      // The low run that ends on this rising edge already takes part in the decision.
      if (sync_in && hi_v_d && lo_v_d) begin
        if (hi_len_d > lo_len_d)      pol_d = 1'b1;
        else if (hi_len_d < lo_len_d) pol_d = 1'b0;
        hi_v_d = 1'b0;
        lo_v_d = 1'b0;
      end
    end else if (cnt_en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q  <= 1'b0;
      cnt_q    <= '0;
      hi_len_q <= '0;
      lo_len_q <= '0;
      hi_v_q   <= 1'b0;
      lo_v_q   <= 1'b0;
      pol_q    <= 1'b0;
    end else begin
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      hi_len_q <= hi_len_d;
      lo_len_q <= lo_len_d;
      hi_v_q   <= hi_v_d;
      lo_v_q   <= lo_v_d;
      pol_q    <= pol_d;
    end
  end

  assign pol = pol_q;

endmodule

// File: rtl/vdc_video_out.sv
// VDC output stage: RGBI palette expansion, blanking, sync polarity normalisation, pixel CE.
module vdc_video_out
  import vdc_pkg::*;
#(
  parameter int unsigned POL_CNT_BITS = 12
) (
  input logic            clk,
  input logic            reset_n,
  vdc_video_out_if.slave vo
);

  logic   hpol, vpol;
  logic   hsync_raw_q;
  logic   hsync_rise;
  logic   ce_q;
  rgb24_t rgb_q, rgb_d;
  logic   hs_q, hs_d;
  logic   vs_q, vs_d;
  logic   hbl_q, vbl_q, field_q;

  // Vertical runs are measured in lines, i.e. sampled rising edges of the raw hsync.
  assign hsync_rise = vo.pixelclk && vo.hsync_in && !hsync_raw_q;

  vdc_syncpol #(.POL_CNT_BITS(POL_CNT_BITS)) u_hpol (
    .clk       (clk),
    .reset_n   (reset_n),
    .cnt_en    (vo.pixelclk),
    .sample_en (vo.pixelclk),
    .sync_in   (vo.hsync_in),
    .pol       (hpol)
  );

  vdc_syncpol #(.POL_CNT_BITS(POL_CNT_BITS)) u_vpol (
    .clk       (clk),
    .reset_n   (reset_n),
    .cnt_en    (hsync_rise),
    .sample_en (vo.pixelclk),
    .sync_in   (vo.vsync_in),
    .pol       (vpol)
  );

  always_comb begin
    rgb_d = rgbi2rgb(vo.rgbi_in);
    if (vo.hblank_in || vo.vblank_in || vo.disable_in) rgb_d = '0;
    hs_d = vo.hsync_in ^ hpol;
    vs_d = vo.vsync_in ^ vpol;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_q        <= 1'b0;
      rgb_q       <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      hbl_q       <= 1'b0;
      vbl_q       <= 1'b0;
      field_q     <= 1'b0;
      hsync_raw_q <= 1'b0;
    end else begin
      ce_q <= vo.pixelclk;
      if (vo.pixelclk) begin
        rgb_q       <= rgb_d;
        hs_q        <= hs_d;
        vs_q        <= vs_d;
        hbl_q       <= vo.hblank_in;
        vbl_q       <= vo.vblank_in;
        field_q     <= vo.field_in;
        hsync_raw_q <= vo.hsync_in;
      end
    end
  end

  assign vo.ce_pix = ce_q;
  assign vo.r      = rgb_q.r;
  assign vo.g      = rgb_q.g;
  assign vo.b      = rgb_q.b;
  assign vo.hs     = hs_q;
  assign vo.vs     = vs_q;
  assign vo.hbl    = hbl_q;
  assign vo.vbl    = vbl_q;
  assign vo.field  = field_q;
  assign vo.hpol   = hpol;
  assign vo.vpol   = vpol;

endmodule

// File: tb/tb_vdc_video_out.sv
// Scoreboard bench for vdc_video_out: palette, blanking, sync polarity, saturation, reset.
module tb_vdc_video_out;
  import vdc_pkg::*;

  typedef struct packed {
    logic [23:0] rgb;
    logic [4:0]  ctl;   // {hs, vs, hbl, vbl, field}
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic exp_hpol = 1'b0;
  logic exp_vpol = 1'b0;
  exp_t sb[$];

  logic [23:0] pal [16] = '{
    24'h000000, 24'h555555, 24'h0000AA, 24'h5555FF,
    24'h00AA00, 24'h55FF55, 24'h00AAAA, 24'h55FFFF,
    24'hAA0000, 24'hFF5555, 24'hAA00AA, 24'hFF55FF,
    24'hAA5500, 24'hFFFF55, 24'hAAAAAA, 24'hFFFFFF
  };

  vdc_video_out_if bus();
  vdc_video_out_if bus4();

  vdc_video_out #(.POL_CNT_BITS(12)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .vo      (bus)
  );

  vdc_video_out #(.POL_CNT_BITS(4)) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .vo      (bus4)
  );

  assign bus4.pixelclk   = bus.pixelclk;
  assign bus4.rgbi_in    = bus.rgbi_in;
  assign bus4.hsync_in   = bus.hsync_in;
  assign bus4.vsync_in   = bus.vsync_in;
  assign bus4.hblank_in  = bus.hblank_in;
  assign bus4.vblank_in  = bus.vblank_in;
  assign bus4.field_in   = bus.field_in;
  assign bus4.disable_in = bus.disable_in;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge; leaves the bench just after a rising edge.
  task automatic strobe(input logic [3:0] c, input logic hsy, input logic vsy, input logic hb,
                        input logic vb, input logic fld, input logic dis, input logic gap);
    exp_t e;
    bus.pixelclk   = 1'b1;
    bus.rgbi_in    = c;
    bus.hsync_in   = hsy;
    bus.vsync_in   = vsy;
    bus.hblank_in  = hb;
    bus.vblank_in  = vb;
    bus.field_in   = fld;
    bus.disable_in = dis;
    e.rgb = (hb || vb || dis) ? 24'h000000 : pal[c];
    e.ctl = {hsy ^ exp_hpol, vsy ^ exp_vpol, hb, vb, fld};
    sb.push_back(e);
    @(posedge clk); #1;
    bus.pixelclk = 1'b0;
    if (gap) begin
      bus.rgbi_in    = 4'($urandom);
      bus.hsync_in   = 1'($urandom);
      bus.vsync_in   = 1'($urandom);
      bus.hblank_in  = 1'($urandom);
      bus.vblank_in  = 1'($urandom);
      bus.field_in   = 1'($urandom);
      bus.disable_in = 1'($urandom);
      @(negedge clk);
      chk("ce_latency", 32'(bus.ce_pix), 32'd1);
      @(posedge clk); @(negedge clk);
      chk("ce_idle", 32'(bus.ce_pix), 32'd0);
      chk("hold_rgb", 32'({bus.r, bus.g, bus.b}), 32'(e.rgb));
      @(posedge clk); #1;
    end
  endtask

  // n back-to-back strobes at one hsync level; newh is the polarity after the first strobe.
  task automatic hrun(input logic lvl, input int unsigned n, input logic newh);
    for (int unsigned i = 0; i < n; i++) begin
      strobe(4'(i), lvl, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 0) exp_hpol = newh;
    end
  endtask

  // n short lines (hsync high 2, low 6) at one vsync level.
  task automatic vrun(input logic lvl, input int unsigned n, input logic newv);
    for (int unsigned l = 0; l < n; l++) begin
      for (int unsigned p = 0; p < 8; p++) begin
        strobe(4'(p), (p < 2), lvl, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (l == 0 && p == 0) exp_vpol = newv;
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
  endtask

  // Monitor: every ce_pix pops one expected pixel.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && bus.ce_pix) begin
        if (sb.size() == 0) begin
          chk("ce_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("pix_rgb", 32'({bus.r, bus.g, bus.b}), 32'(e.rgb));
          chk("pix_ctl", 32'({bus.hs, bus.vs, bus.hbl, bus.vbl, bus.field}), 32'(e.ctl));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    fails++;
    summary();
    $fatal(1, "timeout");
  end

  initial begin
    bus.pixelclk   = 1'b0;
    bus.rgbi_in    = 4'h0;
    bus.hsync_in   = 1'b0;
    bus.vsync_in   = 1'b0;
    bus.hblank_in  = 1'b0;
    bus.vblank_in  = 1'b0;
    bus.field_in   = 1'b0;
    bus.disable_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'({bus.ce_pix, bus.r, bus.g, bus.b}), 32'd0);
    chk("reset_misc", 32'({bus.hs, bus.vs, bus.hbl, bus.vbl, bus.field, bus.hpol, bus.vpol}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int unsigned i = 0; i < 16; i++)
      strobe(4'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'(i), 1'b0, 1'b1);

    strobe(4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    strobe(4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    strobe(4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    strobe(4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    strobe(4'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // H: low 10 / high 118 -> active-low detected on the second rising edge
    hrun(1'b0, 10, 1'b0); hrun(1'b1, 118, 1'b0);
    chk("hpol_line0", 32'(bus.hpol), 32'd0);
    hrun(1'b0, 10, 1'b0); hrun(1'b1, 118, 1'b1);
    chk("hpol_line1", 32'(bus.hpol), 32'd1);
    hrun(1'b0, 10, 1'b1); hrun(1'b1, 118, 1'b1);

    // H flipped: high 10 / low 118; first rising sees 118 vs 118 (held), then 10 vs 118
    hrun(1'b0, 118, 1'b1); hrun(1'b1, 10, 1'b1);
    chk("hpol_flip_eq", 32'(bus.hpol), 32'd1);
    hrun(1'b0, 118, 1'b1); hrun(1'b1, 10, 1'b0);
    chk("hpol_flip", 32'(bus.hpol), 32'd0);
    hrun(1'b0, 118, 1'b0);

    // V: high 4 / low 300 lines
    vrun(1'b1, 4, 1'b0); vrun(1'b0, 300, 1'b0);
    vrun(1'b1, 4, 1'b0);
    chk("vpol_norm", 32'(bus.vpol), 32'd0);
    chk("vpol_norm_sat", 32'(bus4.vpol), 32'd0);
    vrun(1'b0, 300, 1'b0);
    // V inverted: low 4 / high 300 lines
    vrun(1'b0, 4, 1'b0); vrun(1'b1, 300, 1'b0);
    chk("vpol_inv_first", 32'(bus.vpol), 32'd0);
    vrun(1'b0, 4, 1'b0); vrun(1'b1, 300, 1'b1);
    chk("vpol_inv", 32'(bus.vpol), 32'd1);
    chk("vpol_inv_sat", 32'(bus4.vpol), 32'd1);
    // 20 high vs 40 low: full width decides 0, 4-bit counters saturate to equal and hold
    vrun(1'b0, 4, 1'b1); vrun(1'b1, 20, 1'b1); vrun(1'b0, 40, 1'b1); vrun(1'b1, 20, 1'b0);
    chk("vpol_20_40", 32'(bus.vpol), 32'd0);
    chk("vpol_sat_hold", 32'(bus4.vpol), 32'd1);
    vrun(1'b0, 2, 1'b0);

    // Re-establish active-low H, then reset mid-line
    hrun(1'b0, 10, 1'b0); hrun(1'b1, 118, 1'b0);
    hrun(1'b0, 10, 1'b0); hrun(1'b1, 118, 1'b1);
    hrun(1'b0, 5, 1'b1);
    chk("hpol_pre_reset", 32'(bus.hpol), 32'd1);
    idle(3);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_async_rgb", 32'({bus.ce_pix, bus.r, bus.g, bus.b}), 32'd0);
    chk("rst_async_misc", 32'({bus.hs, bus.vs, bus.hbl, bus.vbl, bus.field, bus.hpol, bus.vpol}), 32'd0);
    chk("rst_async_sat", 32'({bus4.hpol, bus4.vpol}), 32'd0);
    exp_hpol = 1'b0;
    exp_vpol = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    hrun(1'b0, 10, 1'b0); hrun(1'b1, 118, 1'b0);
    chk("hpol_reacq0", 32'(bus.hpol), 32'd0);
    hrun(1'b0, 10, 1'b0); hrun(1'b1, 118, 1'b1);
    chk("hpol_reacq1", 32'(bus.hpol), 32'd1);
    hrun(1'b0, 10, 1'b1);

    idle(4);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    summary();
    $finish;
  end

endmodule
